// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: shared cbus request/response types, enums and idle constants
package cbus_arbiter_pkg;
  localparam int CBUS_MAX_MASTERS = 8;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} cbus_burst_t;
  typedef enum logic [2:0] {SIZE_1, SIZE_2, SIZE_4, SIZE_8} cbus_size_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
    cbus_burst_t burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
  localparam cbus_req_t  cbus_req_zero  = '0;
  localparam cbus_resp_t cbus_resp_zero = '0;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder
// Ports: req - request vector; last - previously granted index;
//        winner - first requester after last (wrapping); any_valid - some request set
module rr_picker #(
  parameter int N = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);
  // Scan the search order backwards so the earliest requester overwrites the rest.
  always_comb begin
    winner = '0;
    for (int i = N; i >= 1; i--)
      if (req[IDX_W'((int'(last) + i) % N)]) winner = IDX_W'((int'(last) + i) % N);
    any_valid = |req;
  end
endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: merges several cbus masters onto one memory port, one burst at a time
// Ports: clk, resetn (async, active-low); ireqs/iresps - per-master request/response;
//        oreq/oresp - memory side; grant_idx - granted master (valid while busy);
//        busy - a transaction is in flight
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  localparam int IDX_W = $clog2(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);
  arb_state_t            state;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      winner;
  logic [NUM_INPUTS-1:0] req;
  logic                  any_valid;
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_INPUTS; i++) req[i] = ireqs[i].valid;
  end
  rr_picker #(.N(NUM_INPUTS)) u_pick (
    .req       (req),
    .last      (last_grant),
    .winner    (winner),
    .any_valid (any_valid)
  );
  assign busy = state == ARB_BUSY;
  // Routing is purely combinational from the registered grant; IDLE drives zeros both ways.
  always_comb begin
    oreq = busy ? ireqs[grant_idx] : cbus_req_zero;
    for (int i = 0; i < NUM_INPUTS; i++)
      iresps[i] = (busy && grant_idx == IDX_W'(i)) ? oresp : cbus_resp_zero;
  end
  // grant_idx is cleared on leaving BUSY so it reads 0 whenever idle.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state      <= ARB_IDLE;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_INPUTS - 1);
    end else if (state == ARB_IDLE) begin
      if (any_valid) begin
        state      <= ARB_BUSY;
        grant_idx  <= winner;
        last_grant <= winner;
      end
    end else if (oresp.ready && oresp.last) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
    end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed table-driven and sequence checks for cbus_arbiter
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;
  logic       clk = 0;
  logic       resetn = 0;
  cbus_req_t  ireqs2 [2];
  cbus_resp_t iresps2 [2];
  cbus_req_t  oreq2;
  cbus_resp_t oresp2;
  logic       grant2;
  logic       busy2;
  cbus_req_t  ireqs3 [3];
  cbus_resp_t iresps3 [3];
  cbus_req_t  oreq3;
  cbus_resp_t oresp3;
  logic [1:0] grant3;
  logic       busy3;
  logic [2:0] v3 = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cbus_arbiter #(.NUM_INPUTS(2)) dut2 (
    .clk(clk), .resetn(resetn), .ireqs(ireqs2), .iresps(iresps2),
    .oreq(oreq2), .oresp(oresp2), .grant_idx(grant2), .busy(busy2)
  );
  cbus_arbiter #(.NUM_INPUTS(3)) dut3 (
    .clk(clk), .resetn(resetn), .ireqs(ireqs3), .iresps(iresps3),
    .oreq(oreq3), .oresp(oresp3), .grant_idx(grant3), .busy(busy3)
  );
  always_comb
    for (int i = 0; i < 3; i++) begin
      ireqs3[i] = cbus_req_zero;
      ireqs3[i].valid = v3[i];
    end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [1:0] v;
    logic       rdy, lst;
    logic       busy, g;
    logic [1:0] rr, rl;
  } vec_t;
  vec_t      tbl [15];
  cbus_req_t req_m [2];
  task automatic grant3_once(output logic [1:0] g);
    int n = 0;
    oresp3 = '0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!busy3 && n < 10);
    checks++;
    if (!busy3) begin
      errors++;
      $display("FAIL rr3_timeout: got busy=%0b expected busy=1", busy3);
    end
    g = grant3;
    oresp3 = '{ready: 1'b1, last: 1'b1, data: 32'h0};
    @(negedge clk);
    oresp3 = '0;
    v3[g] = 1'b0;
  endtask
  initial begin
    cbus_req_t  er;
    cbus_resp_t ep;
    logic [1:0] g;
    int beat, cyc;
    logic rdy;
    req_m[0] = cbus_req_zero;
    req_m[0].addr = 32'h8000_0040;
    req_m[0].data = 32'h1111_0000;
    req_m[0].size = SIZE_4;
    req_m[0].burst = BURST_INCR;
    req_m[1] = cbus_req_zero;
    req_m[1].addr = 32'h0000_1000;
    req_m[1].is_write = 1'b1;
    req_m[1].strobe = 4'hf;
    req_m[1].data = 32'h2222_0000;
    req_m[1].size = SIZE_4;
    req_m[1].burst = BURST_INCR;
    tbl[0]  = '{2'b00, 1, 1, 0, 0, 2'b00, 2'b00};
    tbl[1]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[2]  = '{2'b11, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[3]  = '{2'b11, 0, 0, 1, 0, 2'b00, 2'b00};
    tbl[4]  = '{2'b11, 1, 1, 1, 0, 2'b01, 2'b01};
    tbl[5]  = '{2'b10, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[6]  = '{2'b10, 1, 0, 1, 1, 2'b10, 2'b00};
    tbl[7]  = '{2'b10, 1, 1, 1, 1, 2'b10, 2'b10};
    tbl[8]  = '{2'b11, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[9]  = '{2'b11, 1, 1, 1, 0, 2'b01, 2'b01};
    tbl[10] = '{2'b11, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[11] = '{2'b11, 1, 1, 1, 1, 2'b10, 2'b10};
    tbl[12] = '{2'b11, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[13] = '{2'b11, 1, 1, 1, 0, 2'b01, 2'b01};
    tbl[14] = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00};
    ireqs2[0] = '0;
    ireqs2[1] = '0;
    oresp2 = '0;
    oresp3 = '0;
    #2;
    chk("reset_busy", 128'(busy2), 128'(0));
    chk("reset_oreq", 128'(oreq2), 128'(0));
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        ireqs2[m] = req_m[m];
        ireqs2[m].valid = tbl[i].v[m];
      end
      oresp2 = '{ready: tbl[i].rdy, last: tbl[i].lst, data: 32'hDEAD_BEEF};
      #1;
      chk($sformatf("t%0d_busy", i), 128'(busy2), 128'(tbl[i].busy));
      chk($sformatf("t%0d_grant", i), 128'(grant2), 128'(tbl[i].busy ? tbl[i].g : 1'b0));
      er = req_m[tbl[i].g];
      er.valid = 1'b1;
      chk($sformatf("t%0d_oreq", i), 128'(oreq2), 128'(tbl[i].busy ? er : cbus_req_zero));
      for (int m = 0; m < 2; m++) begin
        ep = '{ready: tbl[i].rr[m], last: tbl[i].rl[m],
               data: (tbl[i].busy && tbl[i].g == m[0]) ? 32'hDEAD_BEEF : 32'h0};
        chk($sformatf("t%0d_iresp%0d", i, m), 128'(iresps2[m]), 128'(ep));
      end
    end
    @(negedge clk);
    ireqs2[0] = '0;
    ireqs2[1] = req_m[1];
    ireqs2[1].valid = 1'b1;
    ireqs2[1].len = 8'd15;
    ireqs2[1].data = 32'd0;
    oresp2 = '0;
    #1;
    chk("bw_idle", 128'(busy2), 128'(0));
    beat = 0;
    cyc = 0;
    while (beat < 16 && cyc < 100) begin
      @(negedge clk);
      rdy = cyc[0];
      ireqs2[1].data = 32'(beat);
      oresp2 = '{ready: rdy, last: rdy && beat == 15, data: 32'h0};
      #1;
      chk($sformatf("bw_busy_b%0d", beat), 128'(busy2), 128'(1));
      chk($sformatf("bw_odata_b%0d", beat), 128'(oreq2.data), 128'(beat));
      chk($sformatf("bw_resp0_b%0d", beat), 128'(iresps2[0]), 128'(0));
      chk($sformatf("bw_rdy1_b%0d", beat), 128'(iresps2[1].ready), 128'(rdy));
      if (rdy) beat++;
      cyc++;
    end
    @(negedge clk);
    ireqs2[1] = '0;
    oresp2 = '0;
    #1;
    chk("bw_done_idle", 128'(busy2), 128'(0));
    @(negedge clk);
    ireqs2[0] = req_m[0];
    ireqs2[0].valid = 1'b1;
    ireqs2[0].len = 8'd7;
    #1;
    @(negedge clk);
    #1;
    chk("rst_pre_busy", 128'(busy2), 128'(1));
    chk("rst_pre_grant", 128'(grant2), 128'(0));
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      oresp2 = '{ready: 1'b1, last: 1'b0, data: 32'(b)};
      #1;
      chk($sformatf("rst_beat%0d", b), 128'(iresps2[0]), 128'({1'b1, 1'b0, 32'(b)}));
    end
    @(negedge clk);
    ireqs2[1] = req_m[1];
    ireqs2[1].valid = 1'b1;
    oresp2 = '{ready: 1'b1, last: 1'b0, data: 32'h55};
    #1;
    resetn = 0;
    #1;
    chk("rst_ovalid", 128'(oreq2.valid), 128'(0));
    chk("rst_busy", 128'(busy2), 128'(0));
    chk("rst_resp0", 128'(iresps2[0]), 128'(0));
    @(negedge clk);
    resetn = 1;
    oresp2 = '0;
    #1;
    chk("rst_rel_idle", 128'(busy2), 128'(0));
    @(negedge clk);
    #1;
    chk("rst_rel_busy", 128'(busy2), 128'(1));
    chk("rst_rel_grant", 128'(grant2), 128'(0));
    chk("rst_rel_len", 128'(oreq2.len), 128'(7));
    oresp2 = '{ready: 1'b1, last: 1'b1, data: 32'h0};
    @(negedge clk);
    ireqs2[0] = '0;
    ireqs2[1] = '0;
    oresp2 = '0;
    v3 = 3'b001;
    grant3_once(g);
    chk("rr3_first", 128'(g), 128'(0));
    v3 = 3'b010;
    grant3_once(g);
    chk("rr3_second", 128'(g), 128'(1));
    v3 = 3'b111;
    grant3_once(g);
    chk("rr3_all_a", 128'(g), 128'(2));
    grant3_once(g);
    chk("rr3_all_b", 128'(g), 128'(0));
    grant3_once(g);
    chk("rr3_all_c", 128'(g), 128'(1));
    @(negedge clk);
    #1;
    chk("rr3_idle", 128'(busy3), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
